// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that sits directly in front of the decoder. It owns
// the program counter and issues one instruction-memory request at a time.
// Each returned 32-bit word is held, together with its PC, and presented to
// decode over a valid/ready handshake. Redirects from branch/jump resolution
// replace the PC. A fetch that is already in flight when a redirect arrives is
// drained, and its response is discarded.
//
// Optional build macro:
//   FETCH_PREDECODE_EN - when defined, a direct jump (opcode insn[31:27] ==
//                        00001 j or 00011 jal) accepted by decode steers the
//                        next fetch to insn[PC_W-1:0] without waiting for an
//                        external redirect. A simultaneous redirect still wins.
//
// Parameters:
//   RESET_PC        - PC value loaded on reset
//   PC_W            - PC / instruction-memory word-address width
//
// Ports:
//   clock           in   sole clock, rising edge
//   reset           in   asynchronous, active-low reset
//   imem_req        out  fetch request strobe (one cycle per request)
//   imem_addr       out  word address of the request (the current PC)
//   imem_valid      in   response strobe, at least one cycle after the request
//   imem_data       in   instruction word, meaningful while imem_valid = 1
//   insn_valid      out  held instruction available to decode
//   insn_ready      in   decode accepts the held instruction
//   insn            out  held instruction word
//   insn_pc         out  word address of insn
//   redirect        in   replace the PC with redirect_target
//   redirect_target in   new PC
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned RESET_PC = 0,
  parameter int          PC_W     = 12
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [31:0]     insn,
  output logic [PC_W-1:0] insn_pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target
);

  // IDLE  : only reachable from reset
  // FETCH : request strobe is up this cycle
  // WAIT  : request outstanding, its response is wanted
  // HOLD  : instruction presented to decode
  // DRAIN : request outstanding, its response is stale and will be dropped
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] accept_pc;

  // PC arithmetic wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + PC_W'(1);
  endfunction

`ifdef FETCH_PREDECODE_EN
  function automatic logic is_direct_jump(input logic [4:0] opcode);
    return (opcode == 5'b00001) || (opcode == 5'b00011);
  endfunction

  // pc already points past the held word; a direct jump overrides it.
  assign accept_pc = is_direct_jump(insn[31:27]) ? insn[PC_W-1:0] : pc;
`else
  assign accept_pc = pc;
`endif

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= PC_W'(RESET_PC);
      insn       <= '0;
      insn_pc    <= '0;
      insn_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) begin
            pc         <= redirect_target;
            insn_valid <= 1'b0;
          end
          state <= FETCH;
        end

        FETCH: begin
          // A redirect here leaves the just-issued request outstanding.
          if (redirect) begin
            pc    <= redirect_target;
            state <= DRAIN;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect) begin
            pc <= redirect_target;
            // Response in the same cycle is dropped; otherwise it is still
            // owed to us and must be drained before the next request.
            state <= imem_valid ? FETCH : DRAIN;
          end else if (imem_valid) begin
            insn       <= imem_data;
            insn_pc    <= pc;
            insn_valid <= 1'b1;
            pc         <= pc_inc(pc);
            state      <= HOLD;
          end
        end

        HOLD: begin
          // With redirect and insn_ready together, decode still takes the
          // word; only the next PC comes from the redirect target.
          if (redirect) begin
            pc         <= redirect_target;
            insn_valid <= 1'b0;
            state      <= FETCH;
          end else if (insn_ready) begin
            pc         <= accept_pc;
            insn_valid <= 1'b0;
            state      <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect) begin
            pc <= redirect_target;
          end
          if (imem_valid) begin
            state <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues one request at a time to instruction memory. Presents each returned 32-bit instruction, with its PC, to decode over a valid/ready handshake. Accepts PC redirects from branch/jump resolution and discards any stale in-flight fetch.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset.
- `PC_W`, default 12: PC and instruction-memory word-address width.

Ports:
- `clock` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request strobe.
- `imem_addr` out PC_W: word address of the request.
- `imem_valid` in 1: response strobe. Arrives ≥1 cycle after the request cycle.
- `imem_data` in 32: instruction word; valid when `imem_valid`=1.
- `insn_valid` out 1: held instruction available to decode.
- `insn_ready` in 1: decode accepts the held instruction.
- `insn` out 32: held instruction word.
- `insn_pc` out PC_W: word address of `insn`.
- `redirect` in 1: replace the PC with `redirect_target`.
- `redirect_target` in PC_W: new PC.

## Operation
**Registers**
- Registers: `pc`, `state`, `insn`, `insn_pc`, `insn_valid`.
- `imem_addr` = `pc`.
- `imem_req` = (state==FETCH), decoded from state flops.

**Reset values**
- state=IDLE, pc=RESET_PC, insn=0, insn_pc=0, insn_valid=0, imem_req=0.

**States**
- IDLE: entered only from reset. Next state is FETCH.
- FETCH: `imem_req`=1 for exactly one cycle. Next state is WAIT.
- WAIT: on `imem_valid`, capture insn←imem_data, insn_pc←pc, insn_valid←1, pc←pc+1. Next state is HOLD.
- HOLD: `insn_valid`=1, with `insn`/`insn_pc` stable. On `insn_valid`&`insn_ready`: clear insn_valid and go to FETCH. Otherwise stay.
- DRAIN: a request is outstanding whose response is stale. On `imem_valid`, drop the data and go to FETCH.

**Redirect (priority over every other action)**
- In IDLE or HOLD: pc←target, insn_valid←0, go to FETCH.
  - In HOLD with `insn_ready`=1 in the same cycle, the handshake still completes: decode owns that instruction, but the PC comes from the target.
- In FETCH: pc←target, go to DRAIN. The issued request is outstanding.
- In WAIT without `imem_valid`: pc←target, go to DRAIN.
- In WAIT with `imem_valid`: drop the data, pc←target, go to FETCH.
- In DRAIN without `imem_valid`: pc←target, stay in DRAIN.
- In DRAIN with `imem_valid`: drop the data, pc←target, go to FETCH.

**Other rules**
- `imem_valid` outside WAIT/DRAIN is ignored.
- PC arithmetic is modulo 2^PC_W: all-ones+1 wraps to 0.
- At most one outstanding request. No new `imem_req` while in WAIT, DRAIN or HOLD.

## Timing
- Reset is asynchronous: outputs take their reset values immediately on `reset`=0, including mid-WAIT. A response arriving after reset release is ignored (state is IDLE).
- First rising edge after release: IDLE→FETCH. `imem_req`=1 with `imem_addr`=RESET_PC in the following cycle.
- Memory latency L≥1: response L cycles after the FETCH cycle. `insn_valid` rises on the edge that samples `imem_valid`.
- Latency from request to `insn_valid` is L+1 edges.
- Minimum issue interval is L+2 cycles per instruction with `insn_ready` tied high.
- Backpressure: `insn`, `insn_pc` and `insn_valid` hold indefinitely while `insn_ready`=0.

## Configuration
- Macro: `FETCH_PREDECODE_EN`.
- Defined: when the HOLD handshake completes and the held opcode `insn[31:27]` is 00001 (j) or 00011 (jal), the next PC is `insn[PC_W-1:0]`. This removes the external redirect for direct jumps.
  - A simultaneous external `redirect` still wins.
  - All other opcodes continue at pc+1.
- Undefined: no predecode logic. Direct jumps rely on `redirect` like every other control transfer.

## Test plan
- Reset release, RESET_PC=0, L=1, memory returns 0x28000000 then 0x00000000:
  - `imem_req`@addr 0.
  - `insn`=0x28000000 with `insn_pc`=0.
  - Next request at addr 1.
- Hold `insn_ready`=0 for 5 cycles in HOLD -> `insn`/`insn_pc`/`insn_valid` unchanged and no `imem_req`. Then `insn_ready`=1 -> the next request issues one cycle later.
- L=3, `redirect` to 0x040 one cycle after the request -> the returned word is never presented and the next request is at 0x040.
- Also: redirect to 0x080 in the same cycle as `imem_valid` in WAIT -> data dropped and the next request is at 0x080.
- pc=0xFFF (PC_W=12), word accepted -> next `imem_addr`=0x000.
- `reset` low mid-WAIT, response arrives after release -> outputs zero and no `insn_valid` for it; first request after release is at RESET_PC.
- `FETCH_PREDECODE_EN` with held 0x08000123 at pc 0x010, accepted:
  - With macro: next `imem_addr`=0x123.
  - Without macro: next `imem_addr`=0x011.
